// File: rtl/adder_share_arb.sv
// -----------------------------------------------------------------------------
// adder_share_arb
//
// Round-robin arbiter and sequencer that time-shares one 32-bit carry-select
// adder (csa32) among NREQ requesters. A requester is granted in IDLE, its
// operands are added in ADD, and the sum is presented tagged with the
// requester ID in RESP until the downstream accepts it.
//
// Optional build macro: ADDER_SAT_EN
//   defined   -> signed saturation of the sum before it is registered
//   undefined -> plain modulo-2^32 wrap-around, no saturation logic built
//
// Parameters:
//   NREQ       number of requesters (2..8)
//   IDW        requester ID width, derived as $clog2(NREQ)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  [NREQ]     per-requester operand valid
//   req_ready  [NREQ]     per-requester accept, one-hot or zero, IDLE only
//   req_a      [32*NREQ]  operand A, requester i at [32*i +: 32]
//   req_b      [32*NREQ]  operand B, same packing
//   rsp_valid             sum valid, held until rsp_ready
//   rsp_ready             downstream accepts sum
//   rsp_sum    [32]       sum result
//   rsp_id     [IDW]      requester that owns rsp_sum
// -----------------------------------------------------------------------------

// Carry-select adder: the upper half is precomputed for both carry values
// and selected by the carry out of the lower half.
module csa32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [16:0] lo;
    logic [16:0] hi0;
    logic [16:0] hi1;

    assign lo   = {1'b0, a[15:0]}  + {1'b0, b[15:0]} + {16'b0, cin};
    assign hi0  = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    assign hi1  = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;
    assign sum  = {(lo[16] ? hi1[15:0] : hi0[15:0]), lo[15:0]};
    assign cout = lo[16] ? hi1[16] : hi0[16];
endmodule

module adder_share_arb #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_sum,
    output logic [IDW-1:0]       rsp_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] id_r;
    logic [31:0]    op_a;
    logic [31:0]    op_b;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [31:0]    add_sum;
    logic [31:0]    add_result;
    logic           unused_cout;

    // Search upward from rr_ptr, wrapping modulo NREQ; the first valid wins.
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latch is inferred and later lines see earlier ones.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found && req_valid[(int'(rr_ptr) + i) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end

    // Accept is combinational in IDLE so the handshake completes in the grant
    // cycle; held low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    csa32 u_csa32 (
        .a    (op_a),
        .b    (op_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (unused_cout)
    );

`ifdef ADDER_SAT_EN
    // Signed overflow: both operands share a sign that the sum does not.
    always_comb begin
        add_result = add_sum;
        if ((op_a[31] == op_b[31]) && (add_sum[31] != op_a[31])) begin
            add_result = op_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end
`else
    assign add_result = add_sum;
`endif

    // NOTE: state uses non-blocking '<=' so every register samples pre-edge
    // values; all registers here are small flops, so all take the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_r      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        op_a   <= req_a[32*gnt_idx +: 32];
                        op_b   <= req_b[32*gnt_idx +: 32];
                        id_r   <= gnt_idx;
                        rr_ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    rsp_sum   <= add_result;
                    rsp_id    <= id_r;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // Return to IDLE first; any pending request is granted
                    // in the following IDLE cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arb.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arb
//
// Self-checking bench for adder_share_arb (NREQ=4). A reference model tracks
// the round-robin pointer as an integer and computes expected sums with
// signed 64-bit arithmetic (clamped when ADDER_SAT_EN is defined). Inputs are
// driven 2 time units after the rising edge and outputs checked after that.
// -----------------------------------------------------------------------------
module tb_adder_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_sum;
    logic [IDW-1:0]       rsp_id;

    logic [31:0] a_v [NREQ];
    logic [31:0] b_v [NREQ];

    int checks    = 0;
    int errors    = 0;
    int model_ptr = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = a_v[i];
            req_b[32*i +: 32] = b_v[i];
        end
    end

    adder_share_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected sum from the arithmetic rules, not from the adder structure.
    function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'(signed'(a)) + longint'(signed'(b));
`ifdef ADDER_SAT_EN
        if (s > longint'(32'sh7FFF_FFFF)) return 32'h7FFF_FFFF;
        if (s < -longint'(64'h8000_0000)) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    function automatic int exp_grant(input logic [NREQ-1:0] mask);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[(model_ptr + i) % NREQ]) return (model_ptr + i) % NREQ;
        end
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One full transaction starting in an IDLE cycle: grant, ADD, RESP held
    // for bp cycles with rsp_ready low, then accepted; ends in the next IDLE.
    task automatic txn(input logic [NREQ-1:0] mask, input int bp, input string tag);
        int          g;
        logic [31:0] es;
        req_valid = mask;
        rsp_ready = (bp == 0);
        #1;
        g  = exp_grant(mask);
        es = ref_sum(a_v[g], b_v[g]);
        check({tag, " grant"}, 32'(req_ready), 32'(1 << g));
        check({tag, " idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
        model_ptr = (g + 1) % NREQ;
        step();
        check({tag, " add_ready"}, 32'(req_ready), 32'd0);
        check({tag, " add_rsp_valid"}, 32'(rsp_valid), 32'd0);
        step();
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " rsp_sum"}, rsp_sum, es);
        check({tag, " rsp_id"}, 32'(rsp_id), 32'(g));
        for (int k = 0; k < bp; k++) begin
            step();
            check({tag, " bp_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " bp_sum"}, rsp_sum, es);
            check({tag, " bp_id"}, 32'(rsp_id), 32'(g));
            check({tag, " bp_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        check({tag, " rsp_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic single(input int idx, input logic [31:0] a, input logic [31:0] b, input string tag);
        a_v[idx] = a;
        b_v[idx] = b;
        txn(NREQ'(1 << idx), 0, tag);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = 32'(i + 1) * 32'h0101_0101;
            b_v[i] = 32'(i) * 32'h0010_0003 + 32'd7;
        end
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        #3;
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_sum", rsp_sum, 32'd0);
        check("reset rsp_id", 32'(rsp_id), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // No requests: stays idle, nothing granted, pointer unchanged.
        for (int k = 0; k < 3; k++) begin
            step();
            check("idle req_ready", 32'(req_ready), 32'd0);
            check("idle rsp_valid", 32'(rsp_valid), 32'd0);
        end

        // Fairness: all valid, rsp_ready held high -> 0,1,2,3,0,1 at 3-cycle spacing.
        for (int k = 0; k < 6; k++) begin
            txn('1, 0, "rr");
        end

        // Single request from requester 2.
        single(2, 32'h0000_0005, 32'h0000_0003, "single");

        // Backpressure for 5 cycles.
        a_v[1] = 32'h1234_5678;
        b_v[1] = 32'h1111_1111;
        txn(4'b0010, 5, "backpressure");

        // Wrap / overflow and carry chain.
        single(0, 32'h7FFF_FFFF, 32'h0000_0001, "pos_ovf");
        single(3, 32'h8000_0000, 32'h8000_0000, "neg_ovf");
        single(1, 32'h0000_FFFF, 32'h0000_0001, "carry16");
        single(2, 32'hFFFF_FFFF, 32'h0000_0001, "carry32");
        single(0, 32'h8000_0000, 32'hFFFF_FFFF, "neg_ovf2");

        // Randomized masks, operands and backpressure.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                a_v[i] = $urandom;
                b_v[i] = $urandom;
            end
            txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), int'($urandom_range(0, 3)), "random");
        end

        // Reset during ADD: transaction dropped, pointer back to 0.
        a_v[2] = 32'h0000_0100;
        b_v[2] = 32'h0000_0200;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        rst = 1'b1;
        #1;
        check("rst_mid rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid req_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        model_ptr = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_mid no_rsp", 32'(rsp_valid), 32'd0);
        end
        a_v[1] = 32'h0000_0010;
        b_v[1] = 32'h0000_0020;
        a_v[3] = 32'h0000_0030;
        b_v[3] = 32'h0000_0040;
        txn(4'b1010, 0, "post_reset");
        txn(4'b1010, 1, "post_reset2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer that time-shares one 32-bit carry-select adder (csa32, instantiated internally) among NREQ requesters in the convolution datapath.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester, runs the add, and returns the sum tagged with the requester ID on a single response channel.
- Sits between the MAC partial-product stages and the accumulator writeback, so that only one adder instance is built.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, $clog2(NREQ), width of the requester ID (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester grant/accept; at most one bit high.
- req_a  input  32*NREQ  operand A; requester i uses bits [32*i+31:32*i].
- req_b  input  32*NREQ  operand B; same packing as req_a.
- rsp_valid  output  1  sum valid.
- rsp_ready  input  1  downstream accepts sum.
- rsp_sum  output  32  sum result.
- rsp_id  output  IDW  index of the requester that owns rsp_sum.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, operand regs=0.
  - rsp_valid=0, rsp_sum=0, rsp_id=0, req_ready=0.
- State machine: IDLE -> ADD -> RESP -> IDLE.
- IDLE:
  - If any req_valid is high, grant g = the first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle; the handshake completes that cycle.
  - On that edge: capture req_a[g] and req_b[g] into op_a/op_b, capture g into id_r, set rr_ptr=(g+1) mod NREQ, go to ADD.
  - If no req_valid is high: stay in IDLE, req_ready=0, rr_ptr unchanged.
- ADD:
  - The adder computes op_a+op_b, carry-in 0, from registers.
  - At end of cycle: rsp_sum<=result, rsp_id<=id_r, rsp_valid<=1, go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; rsp_sum and rsp_id held stable until the handshake.
  - req_ready=0.
  - When rsp_ready=1: rsp_valid<=0 on that edge, go to IDLE.
  - rsp_valid is never withdrawn before rsp_ready.
- Latency: request accepted at cycle T -> rsp_valid high at T+2. Minimum spacing between grants is 3 cycles (T, T+3, ...).
- req_ready is only ever asserted in IDLE and is one-hot or zero.
- Requesters hold req_valid and operands until granted. A requester that drops req_valid before grant is simply skipped.
- Arithmetic: 32-bit two's-complement add, carry-out discarded, result wraps modulo 2^32 (unless the optional feature is enabled).
- rsp_ready high in IDLE or ADD: ignored.
- rsp_ready high in RESP during the same cycle new requests are pending: the block returns to IDLE first. The next grant is evaluated in the IDLE cycle; there is no bypass.
- Reset asserted mid-operation:
  - The in-flight transaction is dropped immediately; there is no response.
  - All registers return to reset values asynchronously.

Optional Feature:
- Macro: ADDER_SAT_EN.
- Defined:
  - Signed saturation is applied in ADD before the result is registered.
  - Overflow = (op_a[31]==op_b[31]) && (sum[31]!=op_a[31]).
  - On positive overflow, rsp_sum=32'h7FFF_FFFF; on negative overflow, rsp_sum=32'h8000_0000.
  - Latency is unchanged.
- Undefined: plain wrap-around result; no saturation logic is built.

Test Plan:
- Single request: requester 2 only, A=32'h0000_0005, B=32'h0000_0003 -> req_ready[2] high in that cycle; rsp_valid at T+2 with rsp_sum=8, rsp_id=2.
- Round-robin fairness: all 4 requesters hold valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1 at 3-cycle spacing; responses carry matching IDs and sums.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_sum and rsp_id held constant, no req_ready asserted; rsp_ready=1 -> rsp_valid drops, next grant one cycle later.
- Wrap/overflow: A=32'h7FFF_FFFF, B=1 -> rsp_sum=32'h8000_0000 without ADDER_SAT_EN, 32'h7FFF_FFFF with it. A=B=32'h8000_0000 -> 0 without it, 32'h8000_0000 with it.
- Carry chain: A=32'h0000_FFFF, B=1 -> 32'h0001_0000 (carry across the 16-bit boundary). A=32'hFFFF_FFFF, B=1 -> 0.
- Reset mid-op: assert rst during ADD -> rsp_valid stays 0, no response emitted, rr_ptr=0; the next request from requesters 1 and 3 grants 1 first.
